// File: rtl/fb_scroll_arbiter_if.sv
// Frame-buffer, spectrum-BRAM and video-timing signals shared by the scroll arbiter.
// master = arbiter side, slave = video timing / memories side.
interface fb_scroll_arbiter_if;
   logic [8:0]  x;
   logic [7:0]  y;
   logic        lower_blank;
   logic        clear_req;
   logic        line_valid;
   logic        line_ack;
   logic [8:0]  bin_addr;
   logic        bin_ren;
   logic [7:0]  bin_rdata;
   logic [16:0] fb_addr;
   logic [7:0]  fb_wdata;
   logic        fb_we;
   logic [7:0]  y_offset;
   logic        busy;

   modport master (
      input  x, y, lower_blank, clear_req, line_valid, bin_rdata,
      output line_ack, bin_addr, bin_ren, fb_addr, fb_wdata, fb_we, y_offset, busy
   );

   modport slave (
      output x, y, lower_blank, clear_req, line_valid, bin_rdata,
      input  line_ack, bin_addr, bin_ren, fb_addr, fb_wdata, fb_we, y_offset, busy
   );
endinterface

// File: rtl/fb_scroll_arbiter.sv
// Sole master of the single-port frame buffer: clears it, serves video reads, and
// writes one spectrum line into a circular row buffer every 2^SCROLL_DIV_W frames.
module fb_scroll_arbiter #(
   parameter int H_VISIBLE    = 320,
   parameter int V_VISIBLE    = 240,
   parameter int SCROLL_DIV_W = 2
) (
   input  logic                clk,
   input  logic                resetn,
   fb_scroll_arbiter_if.master bus
);
   typedef enum logic [1:0] {S_CLEAR, S_VIDEO, S_LINE_WRITE, S_WAIT_BLANK} state_t;

   localparam logic [16:0] FB_WORDS = 17'(H_VISIBLE * V_VISIBLE);
   localparam logic [16:0] H17      = 17'(H_VISIBLE);
   localparam logic [8:0]  H9       = 9'(H_VISIBLE);
   localparam logic [8:0]  LAST_BIN = 9'(H_VISIBLE - 1);
   localparam logic [8:0]  V9       = 9'(V_VISIBLE);
   localparam logic [7:0]  LAST_ROW = 8'(V_VISIBLE - 1);

   state_t                  state;
   logic [16:0]             clr_cnt;
   logic [SCROLL_DIV_W-1:0] frame_cnt;
   logic                    clear_pend;
   logic                    rd_busy;
   logic                    rd_dv;
   logic [8:0]              wr_k;
   logic [8:0]              row_sum;
   logic [8:0]              row;
   logic [16:0]             line_base;
   logic                    clear_now;

   always_comb begin
      row_sum   = {1'b0, bus.y} + {1'b0, bus.y_offset};
      row       = (row_sum >= V9) ? row_sum - V9 : row_sum;
      line_base = H17 * 17'(bus.y_offset);
      clear_now = clear_pend | bus.clear_req;
      bus.busy  = (state == S_CLEAR) || (state == S_LINE_WRITE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= S_CLEAR;
         clr_cnt      <= '0;
         frame_cnt    <= '0;
         clear_pend   <= 1'b0;
         rd_busy      <= 1'b0;
         rd_dv        <= 1'b0;
         wr_k         <= '0;
         bus.fb_we    <= 1'b0;
         bus.fb_addr  <= '0;
         bus.fb_wdata <= '0;
         bus.bin_ren  <= 1'b0;
         bus.bin_addr <= '0;
         bus.line_ack <= 1'b0;
         bus.y_offset <= '0;
      end else begin
         bus.line_ack <= 1'b0;
         clear_pend   <= clear_now;
         case (state)
            S_CLEAR: begin
               if (clr_cnt == FB_WORDS) begin
                  bus.fb_we    <= 1'b0;
                  bus.fb_addr  <= '0;
                  bus.y_offset <= '0;
                  state        <= S_WAIT_BLANK;
               end else begin
                  bus.fb_we    <= 1'b1;
                  bus.fb_addr  <= clr_cnt;
                  bus.fb_wdata <= '0;
                  clr_cnt      <= clr_cnt + 17'd1;
               end
            end
            S_VIDEO: begin
               bus.fb_we   <= 1'b0;
               bus.fb_addr <= 17'(bus.x) + H17 * 17'(row);
               if (bus.lower_blank) begin
                  frame_cnt <= frame_cnt + SCROLL_DIV_W'(1);
                  if (clear_now) begin
                     state      <= S_CLEAR;
                     clr_cnt    <= '0;
                     clear_pend <= 1'b0;
                  end else if ((&frame_cnt) && bus.line_valid) begin
                     state        <= S_LINE_WRITE;
                     bus.bin_ren  <= 1'b1;
                     bus.bin_addr <= '0;
                     rd_busy      <= 1'b1;
                     rd_dv        <= 1'b0;
                     wr_k         <= '0;
                  end else begin
                     state <= S_WAIT_BLANK;
                  end
               end
            end
            S_LINE_WRITE: begin
               // Read side runs one cycle ahead; rd_dv marks bin_rdata valid for bin wr_k.
               if (bus.fb_we && (wr_k == H9)) begin
                  bus.fb_we    <= 1'b0;
                  bus.bin_ren  <= 1'b0;
                  bus.line_ack <= 1'b1;
                  bus.y_offset <= (bus.y_offset == LAST_ROW) ? '0 : bus.y_offset + 8'd1;
                  state        <= S_WAIT_BLANK;
               end else begin
                  rd_dv <= rd_busy;
                  if (rd_busy) begin
                     if (bus.bin_addr == LAST_BIN) rd_busy <= 1'b0;
                     else bus.bin_addr <= bus.bin_addr + 9'd1;
                  end
                  if (rd_dv) begin
                     bus.fb_we    <= 1'b1;
                     bus.fb_addr  <= line_base + 17'(wr_k);
                     bus.fb_wdata <= bus.bin_rdata;
                     wr_k         <= wr_k + 9'd1;
                  end else begin
                     bus.fb_we <= 1'b0;
                  end
               end
            end
            S_WAIT_BLANK: begin
               bus.fb_we <= 1'b0;
               if (clear_now && bus.lower_blank) begin
                  state      <= S_CLEAR;
                  clr_cnt    <= '0;
                  clear_pend <= 1'b0;
               end else if (!bus.lower_blank) begin
                  state <= S_VIDEO;
               end
            end
            default: state <= S_CLEAR;
         endcase
      end
   end
endmodule
